// File: rtl/meikyuu_pkg.sv
// Shared constants for the maze game: VGA 640x480 timing, tile/room geometry,
// the map ROM address layout and the collision arbiter FSM states.
package meikyuu_pkg;

  // Horizontal timing (pixels): sync / back porch / active / front porch.
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  // Vertical timing (lines).
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  // Porch-inclusive pixel coordinate width (covers both totals).
  localparam int unsigned PIX_W = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

  localparam int unsigned TILE_W     = 16;
  localparam int unsigned TILE_SHIFT = $clog2(TILE_W);
  localparam int unsigned MAP_ROOMS  = 8;
  localparam int unsigned ROOM_W     = $clog2(MAP_ROOMS);

  // Map ROM address: {room_y, room_x, tile_y, tile_x}.
  localparam int unsigned TX_W   = 6;
  localparam int unsigned TY_W   = 5;
  localparam int unsigned ADDR_W = 2 * ROOM_W + TY_W + TX_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROOM_W-1:0] room_y,
                                                  input logic [ROOM_W-1:0] room_x,
                                                  input logic [TY_W-1:0]   tile_y,
                                                  input logic [TX_W-1:0]   tile_x);
    return {room_y, room_x, tile_y, tile_x};
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping around.
//   req         in   NUM_REQ  request vector
//   ptr         in   PTR_W    index searched first
//   grant_idx   out  PTR_W    selected requester (0 when none)
//   grant_valid out  1        any request set
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/tile_collision_arbiter.sv
// Shares the single-port maze tile ROM among NUM_REQ movers. One requester is
// granted at a time; the four corners of its sprite box are looked up and the
// OR of their wall bits is returned as hit[i] with a one-cycle ack[i].
//   CLOCK_25    in   1           pixel clock
//   reset       in   1           asynchronous, active-high
//   req         in   NUM_REQ     level request, held until ack
//   req_x/y     in   NUM_REQ*10  packed sprite top-left, porch-inclusive
//   req_room_x  in   NUM_REQ*3   packed room column
//   req_room_y  in   NUM_REQ*3   packed room row
//   ack         out  NUM_REQ     result-updated pulse
//   hit         out  NUM_REQ     wall bit per requester
//   rom_addr    out  17          {room_y, room_x, tile_y, tile_x}
//   rom_data    in   1           wall bit, ROM_LAT cycles after rom_addr
//   busy        out  1           service in progress
module tile_collision_arbiter
  import meikyuu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned SPRITE  = 16,
  parameter int unsigned X_ORG   = H_SYNC + H_BACK,
  parameter int unsigned Y_ORG   = V_SYNC + V_BACK
) (
  input  logic                       CLOCK_25,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PIX_W-1:0]   req_x,
  input  logic [NUM_REQ*PIX_W-1:0]   req_y,
  input  logic [NUM_REQ*ROOM_W-1:0]  req_room_x,
  input  logic [NUM_REQ*ROOM_W-1:0]  req_room_y,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         hit,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic                       rom_data,
  output logic                       busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Signed screen coordinate width.
  localparam int unsigned CW = PIX_W + 1;

  arb_state_e          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]    sel_q, sel_d, ptr_q, ptr_d, pick_idx;
  logic                pick_valid;
  logic [PIX_W-1:0]    x_q, x_d, y_q, y_d;
  logic [ROOM_W-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic                acc_q, acc_d;
  logic [ROM_LAT-1:0]  cap_q, cap_d;
  logic [NUM_REQ-1:0]  hit_q, hit_d, ack_q, ack_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d, corner_addr;
  logic [CW-1:0]       sx, sy;
  logic                corner_on, issue_on;
  logic                unused_bits;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req         (req),
    .ptr         (ptr_q),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  // Corner generator: cnt_q[0] selects right edge, cnt_q[1] bottom edge,
  // giving TL, TR, BL, BR over the four issue cycles.
  always_comb begin
    sx = {1'b0, x_q} - CW'(X_ORG) + (cnt_q[0] ? CW'(SPRITE - 1) : '0);
    sy = {1'b0, y_q} - CW'(Y_ORG) + (cnt_q[1] ? CW'(SPRITE - 1) : '0);
    corner_on = !sx[CW-1] && (sx <= CW'(H_ACTIVE - 1)) &&
                !sy[CW-1] && (sy <= CW'(V_ACTIVE - 1));
    corner_addr = tile_addr(ry_q, rx_q, sy[TILE_SHIFT +: TY_W], sx[TILE_SHIFT +: TX_W]);
    unused_bits = ^{sx[TILE_SHIFT-1:0], sy[TILE_SHIFT-1:0], sy[CW-2:TILE_SHIFT+TY_W]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    hit_d       = hit_q;
    ack_d       = '0;
    issue_on    = (state_q == StIssue) && corner_on;
    // Off-screen slots leave the ROM address where it was.
    last_addr_d = issue_on ? corner_addr : last_addr_q;
    // Tag each on-screen issue so its data is captured ROM_LAT cycles later.
    cap_d       = ROM_LAT'({cap_q, issue_on});
    acc_d       = acc_q | (rom_data & cap_q[ROM_LAT-1]);

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          x_d     = req_x[pick_idx*PIX_W +: PIX_W];
          y_d     = req_y[pick_idx*PIX_W +: PIX_W];
          rx_d    = req_room_x[pick_idx*ROOM_W +: ROOM_W];
          ry_d    = req_room_y[pick_idx*ROOM_W +: ROOM_W];
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 2'd1;
        // Last capture lands this cycle; publish the result with the ack.
        if (cnt_q == 2'(ROM_LAT - 1)) begin
          hit_d[sel_q] = acc_d;
          ack_d[sel_q] = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        ptr_d   = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      acc_q       <= 1'b0;
      cap_q       <= '0;
      hit_q       <= '0;
      ack_q       <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      acc_q       <= acc_d;
      cap_q       <= cap_d;
      hit_q       <= hit_d;
      ack_q       <= ack_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign rom_addr = last_addr_d;
  assign ack      = ack_q;
  assign hit      = hit_q;
  assign busy     = (state_q == StIssue) || (state_q == StDrain);

endmodule
